// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path.
// Provides opcode constants, instruction field widths, the {pc, instr}
// entry carried through the fetch queue, and an opcode extraction helper.
package isa_pkg;

   localparam int OPC_W     = 4;
   localparam int JTARGET_W = 12;
   localparam int INSTR_W   = 16;

   localparam logic [OPC_W-1:0] OPC_ADD  = 4'h0;
   localparam logic [OPC_W-1:0] OPC_LW   = 4'h1;
   localparam logic [OPC_W-1:0] OPC_SW   = 4'h2;
   localparam logic [OPC_W-1:0] OPC_JUMP = 4'h6;

   typedef struct packed {
      logic [15:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPC_W];
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: generic synchronous FIFO.
// Ports:
//   clk, rst_n       clock / async active-low reset
//   push, data_in    write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   flush            empties the queue; wins over push/pop in the same cycle
//   data_out         head entry (undefined content when empty)
//   full, empty      occupancy flags
//   count            number of valid entries
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & !empty;
   // A full queue can still accept a push when the head leaves in the same cycle.
   assign do_push  = push & (!full | do_pop);
   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches one 16-bit instruction per
// cycle from a combinational instruction memory, folds J-type jumps, and
// queues {pc, instr} pairs toward decode.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   imem_addr, imem_instr      instruction memory address (= pc) and returned word
//   redirect_valid/_pc         PC change from execute; flushes the queue
//   out_valid/_ready           handshake toward decode
//   out_instr, out_pc          head entry (zero when the queue is empty)
//   halted                     pc is outside instruction memory; fetch stopped
module instruction_fetch_unit
   import isa_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          MEM_WORDS   = 64,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [15:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [15:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [15:0]        out_pc,
   output logic               halted
);

   localparam int          CW       = $clog2(QUEUE_DEPTH) + 1;
   // 17 bits so a full 64K-byte memory still has a representable limit.
   localparam logic [16:0] PC_LIMIT = 17'(2 * MEM_WORDS);

   logic [15:0]  pc;
   logic [15:0]  pc_next;
   logic         pop;
   logic         fetch_en;
   logic         is_jump;
   logic         push;
   fetch_entry_t q_in;
   fetch_entry_t q_head;
   logic         q_full;
   logic         q_empty;
   logic [CW-1:0] q_count;

   assign imem_addr = pc;
   assign halted    = ({1'b0, pc} >= PC_LIMIT);
   assign out_valid = (q_count != '0);
   assign pop       = out_valid & out_ready;
   assign fetch_en  = !halted & !redirect_valid & (!q_full | pop);
   assign is_jump   = (opcode_of(imem_instr) == OPC_JUMP);
   assign push      = fetch_en & !is_jump;
   assign q_in      = '{pc: pc, instr: imem_instr};
   assign out_instr = q_empty ? '0 : q_head.instr;
   assign out_pc    = q_empty ? '0 : q_head.pc;

   always_comb begin
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = redirect_pc & 16'hFFFE;
      end else if (fetch_en) begin
         if (is_jump) pc_next = {3'b000, imem_instr[JTARGET_W-1:0], 1'b0};
         else         pc_next = pc + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_next;
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (redirect_valid),
      .data_in  (q_in),
      .data_out (q_head),
      .full     (q_full),
      .empty    (q_empty),
      .count    (q_count)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst_n;

   logic [15:0] imem_addr, imem_instr;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        out_valid, out_ready, halted;
   logic [15:0] out_instr, out_pc;

   logic [15:0] imem_addr_s, imem_instr_s;
   logic        redirect_valid_s;
   logic [15:0] redirect_pc_s;
   logic        out_valid_s, out_ready_s, halted_s;
   logic [15:0] out_instr_s, out_pc_s;

   logic [15:0] mem [64];

   int total = 0;
   int bad   = 0;

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   instruction_fetch_unit #(.MEM_WORDS(4)) dut_small (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr_s),
      .imem_instr     (imem_instr_s),
      .redirect_valid (redirect_valid_s),
      .redirect_pc    (redirect_pc_s),
      .out_valid      (out_valid_s),
      .out_ready      (out_ready_s),
      .out_instr      (out_instr_s),
      .out_pc         (out_pc_s),
      .halted         (halted_s)
   );

   assign imem_instr   = (imem_addr   < 16'd128) ? mem[imem_addr[6:1]]   : 16'h0000;
   assign imem_instr_s = (imem_addr_s < 16'd128) ? mem[imem_addr_s[6:1]] : 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_instr;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock edge, then return at the following negedge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic ready, input logic ready_s);
      rst_n            = 1'b0;
      out_ready        = ready;
      out_ready_s      = ready_s;
      redirect_valid   = 1'b0;
      redirect_pc      = 16'h0;
      redirect_valid_s = 1'b0;
      redirect_pc_s    = 16'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'(i);
      mem[0] = 16'h1100;
      mem[1] = 16'h1202;
      mem[2] = 16'h0312;
      mem[3] = 16'h2304;
      mem[4] = 16'h6005;
      mem[5] = 16'h0433;

      // Straight-line stream with one folded jump (word 4 -> word 5).
      tbl[0] = '{1'b1, 1'b1, 16'd0,  16'h1100};
      tbl[1] = '{1'b1, 1'b1, 16'd2,  16'h1202};
      tbl[2] = '{1'b1, 1'b1, 16'd4,  16'h0312};
      tbl[3] = '{1'b1, 1'b1, 16'd6,  16'h2304};
      tbl[4] = '{1'b1, 1'b0, 16'd0,  16'h0000};
      tbl[5] = '{1'b1, 1'b1, 16'd10, 16'h0433};
      tbl[6] = '{1'b1, 1'b1, 16'd12, 16'h0006};
      tbl[7] = '{1'b1, 1'b1, 16'd14, 16'h0007};

      rst_n = 1'b0;
      do_reset(1'b1, 1'b0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_pc",    32'(out_pc),    32'd0);
      chk("reset out_instr", 32'(out_instr), 32'd0);
      chk("reset halted",    32'(halted),    32'd0);
      chk("reset imem_addr", 32'(imem_addr), 32'd0);

      // Tests 1 and 2: table-driven stream.
      for (int i = 0; i < 8; i++) begin
         out_ready = tbl[i].ready;
         step();
         chk($sformatf("stream[%0d] valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            chk($sformatf("stream[%0d] pc", i),    32'(out_pc),    32'(tbl[i].exp_pc));
            chk($sformatf("stream[%0d] instr", i), 32'(out_instr), 32'(tbl[i].exp_instr));
         end
         chk($sformatf("stream[%0d] no jump instr", i), 32'(out_valid && out_instr == 16'h6005), 32'd0);
      end

      // Test 3: backpressure fills the queue, then drains without gaps.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall[%0d] valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stall[%0d] pc", i),    32'(out_pc),    32'd0);
      end
      chk("stall imem_addr", 32'(imem_addr), 32'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk($sformatf("drain[%0d] valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("drain[%0d] pc", i),    32'(out_pc),    32'(2 * i));
         chk($sformatf("drain[%0d] instr", i), 32'(out_instr), 32'(mem[i]));
      end

      // Test 4: redirect on a full queue flushes it and clears bit0.
      do_reset(1'b0, 1'b0);
      repeat (3) step();
      chk("pre-redirect head", 32'(out_pc), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h000D;
      step();
      redirect_valid = 1'b0;
      chk("redirect flush valid", 32'(out_valid), 32'd0);
      chk("redirect imem_addr",   32'(imem_addr), 32'd12);
      out_ready = 1'b1;
      step();
      chk("redirect head valid", 32'(out_valid), 32'd1);
      chk("redirect head pc",    32'(out_pc),    32'd12);
      chk("redirect head instr", 32'(out_instr), 32'h0006);
      step();
      chk("redirect next pc",    32'(out_pc),    32'd14);

      // Test 5: small memory halts at pc 8, drains, and resumes on redirect.
      do_reset(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("small[%0d] pc", i),    32'(out_pc_s),    32'(2 * i));
         chk($sformatf("small[%0d] instr", i), 32'(out_instr_s), 32'(mem[i]));
      end
      chk("small halted",    32'(halted_s),    32'd1);
      chk("small imem_addr", 32'(imem_addr_s), 32'd8);
      step();
      chk("small drained valid", 32'(out_valid_s), 32'd0);
      step();
      chk("small still halted",  32'(halted_s),    32'd1);
      chk("small addr held",     32'(imem_addr_s), 32'd8);
      chk("small no output",     32'(out_valid_s), 32'd0);
      redirect_valid_s = 1'b1;
      redirect_pc_s    = 16'h0000;
      step();
      redirect_valid_s = 1'b0;
      chk("small unhalt",       32'(halted_s),    32'd0);
      chk("small redirect pc",  32'(imem_addr_s), 32'd0);
      step();
      chk("small resume valid", 32'(out_valid_s), 32'd1);
      chk("small resume pc",    32'(out_pc_s),    32'd0);

      // Test 6: asynchronous reset mid-stream.
      do_reset(1'b1, 1'b0);
      repeat (3) step();
      chk("pre-async pc", 32'(out_pc), 32'd4);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(out_valid), 32'd0);
      chk("async halted",    32'(halted),    32'd0);
      chk("async imem_addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("restart valid", 32'(out_valid), 32'd1);
      chk("restart pc0",   32'(out_pc),    32'd0);
      step();
      chk("restart pc1",   32'(out_pc),    32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
